// File: rtl/rmt_pkg.sv
// Shared types and constants for the rule-matching steering stage.
package rmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // Default header field byte offsets within the first beat.
  localparam int unsigned ETYPE_OFF_DEF = 12;
  localparam int unsigned DELIM_OFF_DEF = 42;
  localparam int unsigned FUNC_OFF_DEF  = 44;

  // 48-bit lookup key: {func, delim, etype}, each field in raw wire byte order.
  localparam int unsigned FIELD_W       = 16;
  localparam int unsigned KEY_W         = 48;
  localparam int unsigned KEY_ETYPE_LSB = 0;
  localparam int unsigned KEY_DELIM_LSB = 16;
  localparam int unsigned KEY_FUNC_LSB  = 32;

  // Widest tdest a rule entry can hold.
  localparam int unsigned DEST_MAX_W = 8;

  typedef logic [KEY_W-1:0] key_t;

  typedef struct packed {
    logic                  en;
    key_t                  value;
    key_t                  mask;
    logic [DEST_MAX_W-1:0] dest;
    logic                  drop;
  } rule_t;

  function automatic logic key_match(input key_t key, input rule_t r);
    return r.en && (((key ^ r.value) & r.mask) == '0);
  endfunction

endpackage

// File: rtl/rmt_rule_table.sv
// Rule storage with a single write port, parallel compare and priority select.
module rmt_rule_table
  import rmt_pkg::*;
#(
  parameter int unsigned RULE_COUNT = 8,
  parameter int unsigned DEST_WIDTH = 2,
  parameter int unsigned IDX_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic                  cfg_en_i,
  input  logic [KEY_W-1:0]      cfg_value_i,
  input  logic [KEY_W-1:0]      cfg_mask_i,
  input  logic [DEST_WIDTH-1:0] cfg_dest_i,
  input  logic                  cfg_drop_i,
  input  logic [KEY_W-1:0]      key_i,
  output logic                  hit_o,
  output logic [DEST_WIDTH-1:0] dest_o,
  output logic                  drop_o
);

  rule_t tbl_q [RULE_COUNT];

  // Rule write port; every rule disabled on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RULE_COUNT; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_we_i) begin
      tbl_q[cfg_idx_i] <= '{en:    cfg_en_i,
                            value: cfg_value_i,
                            mask:  cfg_mask_i,
                            dest:  DEST_MAX_W'(cfg_dest_i),
                            drop:  cfg_drop_i};
    end
  end

  // Compare all rules; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_o  = 1'b0;
    dest_o = '0;
    drop_o = 1'b0;
    for (int unsigned i = RULE_COUNT; i > 0; i--) begin
      if (key_match(key_i, tbl_q[i-1])) begin
        hit_o  = 1'b1;
        dest_o = DEST_WIDTH'(tbl_q[i-1].dest);
        drop_o = tbl_q[i-1].drop;
      end
    end
  end

endmodule

// File: rtl/rmt_match_steer.sv
// AXI-Stream steering stage: first-beat rule lookup, forward-with-tdest or whole-packet drop.
module rmt_match_steer
  import rmt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH/8,
  parameter int unsigned USER_WIDTH   = 8,
  parameter int unsigned DEST_WIDTH   = 2,
  parameter int unsigned RULE_COUNT   = 8,
  parameter int unsigned ETYPE_OFFSET = ETYPE_OFF_DEF,
  parameter int unsigned DELIM_OFFSET = DELIM_OFF_DEF,
  parameter int unsigned FUNC_OFFSET  = FUNC_OFF_DEF,
  parameter int unsigned DEFAULT_DEST = 0,
  parameter bit          MISS_DROP    = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic                          s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  input  logic                          m_axis_tready,
  input  logic                          cfg_we,
  input  logic [$clog2(RULE_COUNT)-1:0] cfg_idx,
  input  logic                          cfg_en,
  input  logic [47:0]                   cfg_value,
  input  logic [47:0]                   cfg_mask,
  input  logic [DEST_WIDTH-1:0]         cfg_dest,
  input  logic                          cfg_drop,
  output logic [31:0]                   stat_fwd_pkts,
  output logic [31:0]                   stat_drop_pkts
);

  localparam int unsigned IDX_W = $clog2(RULE_COUNT);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic [USER_WIDTH-1:0] user;
    logic [DEST_WIDTH-1:0] dest;
  } beat_t;

  state_e                state_q, state_d;
  logic [DEST_WIDTH-1:0] pkt_dest_q, pkt_dest_d;
  logic                  ready_q, ready_d;
  logic                  out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  beat_t                 out_q, out_d, skid_q, skid_d, in_beat;
  logic [31:0]           fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;

  key_t                  key;
  logic                  tbl_hit, tbl_drop, act_drop, in_acc, fwd_beat, drop_beat;
  logic [DEST_WIDTH-1:0] tbl_dest, act_dest, beat_dest;

  assign key = {s_axis_tdata[8*FUNC_OFFSET  +: FIELD_W],
                s_axis_tdata[8*DELIM_OFFSET +: FIELD_W],
                s_axis_tdata[8*ETYPE_OFFSET +: FIELD_W]};

  rmt_rule_table #(
    .RULE_COUNT (RULE_COUNT),
    .DEST_WIDTH (DEST_WIDTH),
    .IDX_W      (IDX_W)
  ) u_rule_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_en_i    (cfg_en),
    .cfg_value_i (cfg_value),
    .cfg_mask_i  (cfg_mask),
    .cfg_dest_i  (cfg_dest),
    .cfg_drop_i  (cfg_drop),
    .key_i       (key),
    .hit_o       (tbl_hit),
    .dest_o      (tbl_dest),
    .drop_o      (tbl_drop)
  );

  assign act_drop = tbl_hit ? tbl_drop : MISS_DROP;
  assign act_dest = tbl_hit ? tbl_dest : DEST_WIDTH'(DEFAULT_DEST);
  assign in_acc   = s_axis_tvalid && ready_q;
  assign in_beat  = '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast,
                      user: s_axis_tuser, dest: beat_dest};

  // Packet FSM: decide on the first beat, then hold that action until tlast.
  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    beat_dest  = pkt_dest_q;
    fwd_beat   = 1'b0;
    drop_beat  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (in_acc) begin
        beat_dest  = act_dest;
        pkt_dest_d = act_dest;
        fwd_beat   = !act_drop;
        drop_beat  = act_drop;
        if (!s_axis_tlast) state_d = act_drop ? ST_DROP : ST_FWD;
      end
      ST_FWD: if (in_acc) begin
        fwd_beat = 1'b1;
        if (s_axis_tlast) state_d = ST_IDLE;
      end
      ST_DROP: if (in_acc) begin
        drop_beat = 1'b1;
        if (s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register plus skid entry; ready is registered from the next skid state
  // so downstream tready never reaches s_axis_tready combinationally.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (skid_vld_q) begin
      if (m_axis_tready) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (fwd_beat) begin
      if (!out_vld_q || m_axis_tready) begin
        out_d     = in_beat;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = in_beat;
        skid_vld_d = 1'b1;
      end
    end else if (m_axis_tready) begin
      out_vld_d = 1'b0;
    end
    ready_d = !skid_vld_d || (state_d == ST_DROP);
    if (out_vld_q && m_axis_tready && out_q.last) fwd_cnt_d = fwd_cnt_q + 32'd1;
    if (drop_beat && s_axis_tlast)                drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // State, datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pkt_dest_q <= '0;
      ready_q    <= 1'b0;
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
      ready_q    <= ready_d;
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign s_axis_tready  = ready_q;
  assign m_axis_tvalid  = out_vld_q;
  assign m_axis_tdata   = out_q.data;
  assign m_axis_tkeep   = out_q.keep;
  assign m_axis_tlast   = out_q.last;
  assign m_axis_tuser   = out_q.user;
  assign m_axis_tdest   = out_q.dest;
  assign stat_fwd_pkts  = fwd_cnt_q;
  assign stat_drop_pkts = drop_cnt_q;

endmodule

// File: tb/tb_rmt_match_steer.sv
// Directed bench for rmt_match_steer with default parameters.
module tb_rmt_match_steer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [511:0] s_tdata = '0;
  logic [63:0]  s_tkeep = '1;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [7:0]   s_tuser = '0;
  logic         s_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic         m_tvalid, m_tlast;
  logic [7:0]   m_tuser;
  logic [1:0]   m_tdest;
  logic         m_tready = 1'b1;
  logic         cfg_we = 1'b0, cfg_en = 1'b0, cfg_drop = 1'b0;
  logic [2:0]   cfg_idx = '0;
  logic [47:0]  cfg_value = '0, cfg_mask = '0;
  logic [1:0]   cfg_dest = '0;
  logic [31:0]  stat_fwd, stat_drop;

  typedef struct packed {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic [7:0]   user;
    logic [1:0]   dest;
  } beat_t;

  localparam logic [47:0] KEY_HIT = 48'h0001_F0E1_0008;
  localparam logic [47:0] MASK_ALL = 48'hFFFF_FFFF_FFFF;

  int    total = 0, bad = 0;
  int    exp_fwd = 0, exp_drop = 0;
  int    vld_cycles = 0, stab_err = 0;
  beat_t obs_q[$];
  beat_t exp_q[$];
  beat_t cur, prev;
  logic  prev_stall = 1'b0;
  bit    bp_done;

  always #5 clk = ~clk;

  rmt_match_steer dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tdest(m_tdest),
    .m_axis_tready(m_tready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_value(cfg_value),
    .cfg_mask(cfg_mask), .cfg_dest(cfg_dest), .cfg_drop(cfg_drop),
    .stat_fwd_pkts(stat_fwd), .stat_drop_pkts(stat_drop)
  );

  assign cur = {m_tdata, m_tkeep, m_tlast, m_tuser, m_tdest};

  // Output monitor on the inactive edge: records transfers and hold violations.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (m_tvalid) vld_cycles <= vld_cycles + 1;
      if (prev_stall && (m_tvalid !== 1'b1 || cur !== prev)) stab_err <= stab_err + 1;
      if (m_tvalid && m_tready) obs_q.push_back(cur);
      prev_stall <= m_tvalid && !m_tready;
      prev       <= cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] mk_beat(input logic [15:0] et, input logic [15:0] dl,
                                           input logic [15:0] fn, input logic [31:0] tag);
    logic [511:0] d;
    d = '0;
    d[96  +: 16] = et;
    d[336 +: 16] = dl;
    d[352 +: 16] = fn;
    d[480 +: 32] = tag;
    return d;
  endfunction

  // Presents one beat (caller is at posedge+1) and returns at posedge+1 after the transfer.
  task automatic send_beat(input logic [511:0] d, input logic l, input logic [7:0] u,
                           output int waits);
    bit ok;
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    ok = 0; waits = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (s_tready) begin ok = 1; break; end
      waits++;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [47:0] val,
                           input logic [47:0] msk, input logic [1:0] dst, input logic drp);
    cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_value = val;
    cfg_mask = msk; cfg_dest = dst; cfg_drop = drp;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", m_tvalid); end
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b exp=0", s_tready); end
    total++; if (m_tdest !== 2'd0 || m_tlast !== 1'b0 || m_tuser !== 8'd0 || m_tdata !== '0 || m_tkeep !== '0) begin
      bad++; $display("FAIL rst_outputs got dest=%0d last=%b user=%h exp=0", m_tdest, m_tlast, m_tuser);
    end
    total++; if (stat_fwd !== 32'd0 || stat_drop !== 32'd0) begin
      bad++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stat_fwd, stat_drop);
    end
    rst_n = 1'b1;
    #1;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL rel_tready got=%b exp=0", s_tready); end
    @(posedge clk); #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL rel_tready_edge got=%b exp=1", s_tready); end
  endtask

  task automatic test_match_fwd();
    int w;
    cfg_write(3'd0, 1'b1, KEY_HIT, MASK_ALL, 2'd1, 1'b0);
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h100 + i), i == 3, 8'(8'h10 + i), w);
      if (i == 0) begin
        total++; if (m_tvalid !== 1'b1 || m_tdest !== 2'd1) begin
          bad++; $display("FAIL fwd_latency got valid=%b dest=%0d exp valid=1 dest=1", m_tvalid, m_tdest);
        end
      end
    end
    drain();
    exp_fwd++;
    total++; if (obs_q.size() != 4) begin bad++; $display("FAIL fwd_count got=%0d exp=4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i].data !== mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h100 + i) || obs_q[i].dest !== 2'd1 ||
          obs_q[i].last !== (i == 3) || obs_q[i].user !== 8'(8'h10 + i) || obs_q[i].keep !== '1) begin
        bad++;
        $display("FAIL fwd_beat%0d got tag=%h dest=%0d last=%b exp tag=%h dest=1 last=%b",
                 i, obs_q[i].data[511:480], obs_q[i].dest, obs_q[i].last, 32'h100 + i, i == 3);
      end
    end
    total++; if (stat_fwd !== 32'(exp_fwd)) begin bad++; $display("FAIL fwd_stat got=%0d exp=%0d", stat_fwd, exp_fwd); end
  endtask

  task automatic test_miss_drop();
    int w, v0;
    obs_q.delete();
    m_tready = 1'b0;
    v0 = vld_cycles;
    for (int i = 0; i < 3; i++) begin
      send_beat(mk_beat(16'hDD86, 16'hF0E1, 16'h0001, 32'h200 + i), i == 2, 8'h20, w);
      total++; if (w != 0) begin bad++; $display("FAIL drop_ready beat%0d got_waits=%0d exp=0", i, w); end
    end
    repeat (3) @(posedge clk);
    #1;
    exp_drop++;
    total++; if (vld_cycles != v0) begin bad++; $display("FAIL drop_tvalid got=%0d exp=0", vld_cycles - v0); end
    total++; if (stat_drop !== 32'(exp_drop)) begin bad++; $display("FAIL drop_stat got=%0d exp=%0d", stat_drop, exp_drop); end
    m_tready = 1'b1;
    for (int i = 0; i < 2; i++)
      send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h210 + i), i == 1, 8'h21, w);
    drain();
    exp_fwd++;
    total++;
    if (obs_q.size() != 2 || obs_q[0].data[511:480] !== 32'h210 || obs_q[1].data[511:480] !== 32'h211 ||
        obs_q[1].last !== 1'b1 || obs_q[0].dest !== 2'd1) begin
      bad++; $display("FAIL after_drop got_n=%0d exp_n=2", obs_q.size());
    end
    total++; if (stat_fwd !== 32'(exp_fwd)) begin bad++; $display("FAIL after_drop_stat got=%0d exp=%0d", stat_fwd, exp_fwd); end
  endtask

  task automatic test_priority();
    int w;
    cfg_write(3'd0, 1'b1, KEY_HIT, 48'h0000_FFFF_FFFF, 2'd2, 1'b0);
    cfg_write(3'd3, 1'b1, KEY_HIT, MASK_ALL, 2'd3, 1'b0);
    obs_q.delete();
    send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h300), 1'b1, 8'h30, w);
    drain();
    total++; if (obs_q.size() != 1 || obs_q[0].dest !== 2'd2) begin
      bad++; $display("FAIL prio_rule0 got_n=%0d dest=%0d exp dest=2", obs_q.size(), obs_q.size() ? obs_q[0].dest : 2'd0);
    end
    exp_fwd++;
    cfg_write(3'd0, 1'b0, KEY_HIT, 48'h0000_FFFF_FFFF, 2'd2, 1'b0);
    obs_q.delete();
    send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h301), 1'b1, 8'h31, w);
    drain();
    total++; if (obs_q.size() != 1 || obs_q[0].dest !== 2'd3) begin
      bad++; $display("FAIL prio_rule3 got_n=%0d dest=%0d exp dest=3", obs_q.size(), obs_q.size() ? obs_q[0].dest : 2'd0);
    end
    exp_fwd++;
    obs_q.delete();
    send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0005, 32'h302), 1'b1, 8'h32, w);
    drain();
    exp_drop++;
    total++; if (obs_q.size() != 0 || stat_drop !== 32'(exp_drop)) begin
      bad++; $display("FAIL prio_miss got_n=%0d drops=%0d exp_n=0 drops=%0d", obs_q.size(), stat_drop, exp_drop);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    obs_q.delete();
    exp_q.delete();
    s0 = stab_err;
    bp_done = 0;
    fork
      begin
        int w;
        for (int p = 0; p < 5; p++)
          for (int b = 0; b < 4; b++) begin
            exp_q.push_back('{data: mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h400 + p*4 + b),
                              keep: '1, last: b == 3, user: 8'(p), dest: 2'd3});
            send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h400 + p*4 + b), b == 3, 8'(p), w);
          end
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk); #1;
          m_tready = ($urandom_range(0, 99) < 30);
        end
      end
    join
    drain();
    exp_fwd += 5;
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL bp_beat%0d got tag=%h last=%b exp tag=%h last=%b",
                        i, obs_q[i].data[511:480], obs_q[i].last, exp_q[i].data[511:480], exp_q[i].last);
      end
    end
    total++; if (stab_err != s0) begin bad++; $display("FAIL bp_stable got=%0d exp=0", stab_err - s0); end
    total++; if (stat_fwd !== 32'(exp_fwd)) begin bad++; $display("FAIL bp_stat got=%0d exp=%0d", stat_fwd, exp_fwd); end
  endtask

  task automatic test_back_to_back();
    int w, nbad;
    obs_q.delete();
    for (int i = 0; i < 100; i++)
      send_beat(mk_beat((i % 2 == 0) ? 16'h0008 : 16'hDD86, 16'hF0E1, 16'h0001, 32'h1000 + i), 1'b1, 8'h50, w);
    drain();
    exp_fwd += 50;
    exp_drop += 50;
    total++; if (obs_q.size() != 50) begin bad++; $display("FAIL b2b_count got=%0d exp=50", obs_q.size()); end
    nbad = 0;
    for (int i = 0; i < 50 && i < obs_q.size(); i++)
      if (obs_q[i].data[511:480] !== 32'h1000 + 2*i || obs_q[i].last !== 1'b1 || obs_q[i].dest !== 2'd3) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL b2b_beats got_bad=%0d exp=0", nbad); end
    total++; if (stat_fwd !== 32'(exp_fwd)) begin bad++; $display("FAIL b2b_fwd got=%0d exp=%0d", stat_fwd, exp_fwd); end
    total++; if (stat_drop !== 32'(exp_drop)) begin bad++; $display("FAIL b2b_drop got=%0d exp=%0d", stat_drop, exp_drop); end
  endtask

  task automatic test_async_reset();
    int w;
    send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h600), 1'b0, 8'h60, w);
    total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b exp=1", m_tvalid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      bad++; $display("FAIL ar_immediate got valid=%b ready=%b exp 0/0", m_tvalid, s_tready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    obs_q.delete();
    exp_fwd = 0;
    exp_drop = 0;
    total++; if (stat_fwd !== 32'd0 || stat_drop !== 32'd0) begin
      bad++; $display("FAIL ar_counters got=%0d/%0d exp=0/0", stat_fwd, stat_drop);
    end
    @(posedge clk); #1;
    send_beat(mk_beat(16'h0008, 16'hF0E1, 16'h0001, 32'h601), 1'b1, 8'h61, w);
    drain();
    exp_drop++;
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL ar_rules_cleared got_n=%0d exp=0", obs_q.size()); end
    total++; if (stat_drop !== 32'(exp_drop) || stat_fwd !== 32'(exp_fwd)) begin
      bad++; $display("FAIL ar_stat got=%0d/%0d exp=%0d/%0d", stat_fwd, stat_drop, exp_fwd, exp_drop);
    end
  endtask

  initial begin
    test_reset();
    test_match_fwd();
    test_miss_drop();
    test_priority();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
